div_seq: RTL and testbench

Multi-cycle signed 32-bit integer divider for the datapath ALU. It is the inverse operation to the combinational Booth multiplier and uses the same HI/LO result convention: quotient on `zlow` (LO), remainder on `zhigh` (HI). It runs a radix-2 non-restoring algorithm, one quotient bit per clock, under a start/done handshake. The control unit stalls on `busy` and captures results on `done`.

---
 rtl/div_seq.sv | 185 ++++++++++++++++++
 tb/tb_div_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed divider, radix-2 non-restoring, one quotient
// bit per clock. Quotient on zlow (LO), remainder on zhigh (HI).
// Fixed latency: done pulses WIDTH+3 cycles after the accepting edge.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;

  // Latched operands; a_lat is also the remainder reported on divide-by-zero.
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  // Divisor magnitude is WIDTH+1 bits so the add/subtract matches the
  // WIDTH+1-bit partial remainder. The dividend magnitude (up to 2^(WIDTH-1))
  // is held unsigned in the quotient shift register.
  logic [WIDTH:0]   b_mag;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    a_abs = a_lat;
    b_abs = b_lat;
    if (a_lat[WIDTH-1]) begin
      a_abs = ~a_lat + ONE_W;
    end else begin
      a_abs = a_lat;
    end
    if (b_lat[WIDTH-1]) begin
      b_abs = ~b_lat + ONE_W;
    end else begin
      b_abs = b_lat;
    end
  end

  // One non-restoring step: shift in the next dividend bit, then subtract
  // when the partial remainder is non-negative, add when it is negative.
  always_comb begin
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    p_next  = p_shift;
    if (p_reg[WIDTH]) begin
      p_next = p_shift + b_mag;
    end else begin
      p_next = p_shift - b_mag;
    end
    q_next = {q_reg[WIDTH-2:0], ~p_next[WIDTH]};
  end

  // Final correction and sign application. The corrected remainder is below
  // the divisor magnitude, so its low WIDTH bits carry the full value.
  always_comb begin
    r_low = p_reg[WIDTH-1:0];
    if (p_reg[WIDTH]) begin
      r_low = p_reg[WIDTH-1:0] + b_mag[WIDTH-1:0];
    end else begin
      r_low = p_reg[WIDTH-1:0];
    end
    if (q_neg) begin
      q_signed = ~q_reg + ONE_W;
    end else begin
      q_signed = q_reg;
    end
    if (r_neg) begin
      r_signed = ~r_low + ONE_W;
    end else begin
      r_signed = r_low;
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= S_IDLE;
      a_lat       <= {WIDTH{1'b0}};
      b_lat       <= {WIDTH{1'b0}};
      b_mag       <= {(WIDTH+1){1'b0}};
      p_reg       <= {(WIDTH+1){1'b0}};
      q_reg       <= {WIDTH{1'b0}};
      cnt         <= {CW{1'b0}};
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      q_res       <= {WIDTH{1'b0}};
      r_res       <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      zlow        <= {WIDTH{1'b0}};
      zhigh       <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_lat <= dividend;
            b_lat <= divisor;
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          q_reg <= a_abs;
          b_mag <= {1'b0, b_abs};
          p_reg <= {(WIDTH+1){1'b0}};
          q_neg <= a_lat[WIDTH-1] ^ b_lat[WIDTH-1];
          r_neg <= a_lat[WIDTH-1];
          dbz   <= (b_lat == {WIDTH{1'b0}});
          cnt   <= CW'(WIDTH - 1);
          state <= S_ITER;
        end
        S_ITER: begin
          p_reg <= p_next;
          q_reg <= q_next;
          if (cnt == {CW{1'b0}}) begin
            state <= S_FIXUP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FIXUP: begin
          // Divide-by-zero still runs the iterations; only the result differs.
          if (dbz) begin
            q_res <= {WIDTH{1'b1}};
            r_res <= a_lat;
          end else begin
            q_res <= q_signed;
            r_res <= r_signed;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          zlow        <= q_res;
          zhigh       <= r_res;
          div_by_zero <= dbz;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a countdown/arithmetic model compared
// against the DUT every cycle, plus directed literal cases and random operands.
module tb_div_seq;

  localparam int W = 32;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] zlow;
  logic [W-1:0] zhigh;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .clear(clear),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .zlow(zlow),
    .zhigh(zhigh),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: truncating division, remainder follows the dividend.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) q = -1;
    else q = sa / sb;
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) r = sa;
    else r = sa % sb;
    return r[W-1:0];
  endfunction

  // Behavioural model: accept when idle, result appears LAT edges later.
  int           m_rem = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_zlow = '0, m_zhigh = '0;

  // Model update on the same edges the DUT sees.
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_zlow <= '0; m_zhigh <= '0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_a <= dividend; m_b <= divisor; m_rem <= LAT; m_busy <= 1'b1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done  <= 1'b1;
          m_busy  <= 1'b0;
          m_zlow  <= ref_q(m_a, m_b);
          m_zhigh <= ref_r(m_a, m_b);
          m_dbz   <= (m_b == '0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(lat);
    chk({name, "_latency"}, 32'(lat), 32'(LAT));
    chk({name, "_zlow"}, zlow, eq);
    chk({name, "_zhigh"}, zhigh, er);
    chk({name, "_dbz"}, {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, edbz});
  endtask

  initial begin
    int lat1, lat2, ndone;
    logic [W-1:0] ra, rb;
    clear = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Per-cycle comparison of every output against the model.
    fork
      forever begin
        @(negedge clk);
        n_cmp++;
        if ({busy, done, zlow, zhigh, div_by_zero} !== {m_busy, m_done, m_zlow, m_zhigh, m_dbz}) begin
          n_fail++;
          $display("FAIL cycle t=%0t: dut busy=%b done=%b zlow=%h zhigh=%h dbz=%b model busy=%b done=%b zlow=%h zhigh=%h dbz=%b",
                   $time, busy, done, zlow, zhigh, div_by_zero, m_busy, m_done, m_zlow, m_zhigh, m_dbz);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, div_by_zero, 29'd0}, 32'd0);
    chk("reset_zlow", zlow, 32'd0);
    chk("reset_zhigh", zhigh, 32'd0);
    @(negedge clk);
    clear = 1'b1;

    do_op("d42_16",  32'd42, 32'd16, 32'd2, 32'd10, 1'b0);
    do_op("d42_12",  32'd42, 32'd12, 32'd3, 32'd6,  1'b0);
    do_op("d42_21",  32'd42, 32'd21, 32'd2, 32'd0,  1'b0);
    do_op("dn42_16", 32'hFFFF_FFD6, 32'd16, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 1'b0);
    do_op("d42_n16", 32'd42, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'd10, 1'b0);
    do_op("dn42_n16", 32'hFFFF_FFD6, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFF6, 1'b0);
    do_op("d42_0",   32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 1'b1);
    do_op("dmin_n1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_op("d5_7",    32'd5, 32'd7, 32'd0, 32'd5, 1'b0);

    // start pulsed mid-operation is ignored: one done, first result kept.
    @(negedge clk);
    dividend = 32'd42; divisor = 32'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (k == 10) begin
        start = 1'b1; dividend = 32'd7; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignored_start_ndone", 32'(ndone), 32'd1);
    chk("ignored_start_zlow", zlow, 32'd2);
    chk("ignored_start_zhigh", zhigh, 32'd10);

    // start held high: back-to-back results 36 cycles apart.
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat1);
    chk("b2b_first_lat", 32'(lat1), 32'(LAT));
    chk("b2b_first_zlow", zlow, 32'd142);
    chk("b2b_first_zhigh", zhigh, 32'd6);
    dividend = 32'hFFFF_FFB3; divisor = 32'd5;   // -77 / 5
    wait_done(lat2);
    start = 1'b0;
    chk("b2b_spacing", 32'(lat2), 32'(LAT + 1));
    chk("b2b_second_zlow", zlow, 32'hFFFF_FFF1);
    chk("b2b_second_zhigh", zhigh, 32'hFFFF_FFFE);

    // clear mid-iteration aborts with no done.
    @(negedge clk);
    dividend = 32'd42; divisor = 32'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clear = 1'b0;
    #1;
    chk("clear_flags", {busy, done, div_by_zero, 29'd0}, 32'd0);
    chk("clear_zlow", zlow, 32'd0);
    chk("clear_zhigh", zhigh, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("clear_no_done", 32'(ndone), 32'd0);
    do_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Randomized signed operands, non-zero divisor.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'($urandom_range(1, 300)); if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1; end
        2: begin ra = 32'h8000_0000; rb = $urandom >> $urandom_range(0, 31); end
        default: begin ra = $urandom >> $urandom_range(0, 31); rb = $urandom >> $urandom_range(0, 31); end
      endcase
      if (rb == 32'd0) rb = 32'd1;
      do_op("rand", ra, rb, ref_q(ra, rb), ref_r(ra, rb), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
